// File: rtl/bitonic_stream_sorter.sv
// Serial-in/serial-out 8-word bitonic sorter, 4 compare-exchanges per cycle.
// Optional: define BITONIC_STREAM_LAST_EN for in_last/out_last short frames.
module bitonic_stream_sorter #(
  parameter int WIDTH   = 8,
  parameter bit DESCEND = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BITONIC_STREAM_LAST_EN
  input  logic             in_last,
  output logic             out_last,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_OUT
  } state_t;

  localparam logic [WIDTH-1:0] PAD = DESCEND ? '0 : '1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_buf [8];
  logic [WIDTH-1:0] w_sorted [8];
  logic [2:0]       r_idx;
  logic [2:0]       r_step;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_done;
  int               w_k;
  int               w_j;
  logic [2:0]       w_p;
  logic             w_asc;

  assign w_in_fire  = in_valid && (r_state == S_LOAD);
  assign w_out_fire = out_ready && (r_state == S_OUT);

`ifdef BITONIC_STREAM_LAST_EN
  assign w_load_done = w_in_fire && ((r_idx == 3'd7) || in_last);
  assign out_last    = (r_state == S_OUT) && (r_idx == 3'd7);
`else
  assign w_load_done = w_in_fire && (r_idx == 3'd7);
`endif

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = (r_state == S_OUT);
  assign busy      = (r_state != S_LOAD);
  assign out_data  = out_valid ? r_buf[r_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_LOAD:  if (w_load_done) w_next = S_SORT;
      S_SORT:  if (r_step == 3'd5) w_next = S_OUT;
      S_OUT:   if (w_out_fire && r_idx == 3'd7) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  // One (k, j) column of the network; pairs never overlap within a step.
  always_comb begin
    w_k = 8;
    w_j = 1;
    unique case (r_step)
      3'd0:    begin w_k = 2; w_j = 1; end
      3'd1:    begin w_k = 4; w_j = 2; end
      3'd2:    begin w_k = 4; w_j = 1; end
      3'd3:    begin w_k = 8; w_j = 4; end
      3'd4:    begin w_k = 8; w_j = 2; end
      default: begin w_k = 8; w_j = 1; end
    endcase
    w_sorted = r_buf;
    w_p      = '0;
    w_asc    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((i & w_j) == 0) begin
        w_p   = 3'(i | w_j);
        w_asc = ((i & w_k) == 0) ^ DESCEND;
        if (w_asc ? (r_buf[i] > r_buf[w_p])
                  : (r_buf[i] < r_buf[w_p])) begin
          w_sorted[i]   = r_buf[w_p];
          w_sorted[w_p] = r_buf[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_step <= '0;
      for (int s = 0; s < 8; s++) r_buf[s] <= '0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          r_step <= '0;
          if (w_in_fire) begin
            r_buf[r_idx] <= in_data;
`ifdef BITONIC_STREAM_LAST_EN
            if (in_last) begin
              for (int s = 0; s < 8; s++)
                if (s > int'(r_idx)) r_buf[s] <= PAD;
            end
`endif
            r_idx <= w_load_done ? 3'd0 : r_idx + 3'd1;
          end
        end
        S_SORT: begin
          r_buf  <= w_sorted;
          r_idx  <= '0;
          r_step <= (r_step == 3'd5) ? 3'd0 : r_step + 3'd1;
        end
        S_OUT: begin
          if (w_out_fire) r_idx <= r_idx + 3'd1;
        end
        default: begin
          r_idx  <= '0;
          r_step <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_stream_sorter.sv
// Randomized bench for bitonic_stream_sorter: ascending and descending
// instances share stimulus and are checked against a queue-sort model.
module tb_bitonic_stream_sorter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       a_in_ready, a_out_valid, a_busy;
  logic       d_in_ready, d_out_valid, d_busy;
  logic [7:0] a_out_data, d_out_data;
`ifdef BITONIC_STREAM_LAST_EN
  logic       in_last;
  logic       a_out_last, d_out_last;
`endif

  int n_chk;
  int n_fail;
  logic [7:0] r_vec [8];

  bitonic_stream_sorter #(.WIDTH(8), .DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data),
`ifdef BITONIC_STREAM_LAST_EN
    .in_last(in_last), .out_last(a_out_last),
`endif
    .busy(a_busy)
  );

  bitonic_stream_sorter #(.WIDTH(8), .DESCEND(1'b1)) u_dsc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .out_valid(d_out_valid), .out_ready(out_ready),
    .out_data(d_out_data),
`ifdef BITONIC_STREAM_LAST_EN
    .in_last(in_last), .out_last(d_out_last),
`endif
    .busy(d_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n words of r_vec; bpmode 0 = ready, 1 = toggle, 2 = random.
  // abort_at < 8 resets after that many outputs.
  task automatic do_frame(input int n, input int bpmode,
                          input bit noisy, input int abort_at);
    logic [7:0] qa[$];
    logic [7:0] qd[$];
    logic [7:0] prev_a, prev_d;
    bit         stalled;
    int         got, cyc;
    for (int w = 0; w < 8; w++) begin
      qa.push_back(w < n ? r_vec[w] : 8'hff);
      qd.push_back(w < n ? r_vec[w] : 8'h00);
    end
    qa.sort();
    qd.rsort();

    for (int w = 0; w < n; w++) begin
      if (noisy) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = r_vec[w];
`ifdef BITONIC_STREAM_LAST_EN
      in_last  = (w == n - 1);
`endif
      @(negedge clk);
      check("in_ready_load", a_in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = noisy;
    in_data  = 8'($urandom);
`ifdef BITONIC_STREAM_LAST_EN
    in_last  = 1'b0;
`endif

    check("busy_sort", a_busy, 1);
    check("in_ready_sort", a_in_ready, 0);
    for (int c = 1; c <= 6; c++) begin
      check("out_valid_lat", a_out_valid, 32'(c == 1 ? 0 : 0));
      @(posedge clk); #1;
      if (c == 6) check("out_valid_rise", a_out_valid, 1);
      if (c == 6) check("dsc_valid_rise", d_out_valid, 1);
    end

    got = 0;
    cyc = 0;
    stalled = 1'b0;
    prev_a = '0;
    prev_d = '0;
    while (got < 8 && got != abort_at && cyc < 200) begin
      unique case (bpmode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (noisy) in_data = 8'($urandom);
      @(negedge clk);
      check("out_valid", a_out_valid, 1);
      check("in_ready_out", a_in_ready, 0);
      check("busy_out", d_busy, 1);
      if (stalled) begin
        check("stall_hold_a", a_out_data, prev_a);
        check("stall_hold_d", d_out_data, prev_d);
      end
      if (out_ready) begin
        check("data_asc", a_out_data, qa[got]);
        check("data_dsc", d_out_data, qd[got]);
`ifdef BITONIC_STREAM_LAST_EN
        check("out_last_a", a_out_last, got == 7);
        check("out_last_d", d_out_last, got == 7);
`endif
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        prev_a = a_out_data;
        prev_d = d_out_data;
      end
      @(posedge clk); #1;
      if (got == 8) in_valid = 1'b0;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    if (got == abort_at) begin
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", a_out_valid, 0);
      check("abort_in_ready", a_in_ready, 1);
      check("abort_busy", d_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_abort_valid", a_out_valid, 0);
    end else if (got < 8) begin
      check("out_timeout", got, 8);
    end else begin
      check("done_in_ready", a_in_ready, 1);
      check("done_out_valid", a_out_valid, 0);
      check("done_busy", a_busy, 0);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef BITONIC_STREAM_LAST_EN
    in_last   = 1'b0;
`endif
    #12;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_data", a_out_data, 0);
    check("rst_busy", a_busy, 0);
    check("rst_dsc_valid", d_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    r_vec = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    do_frame(8, 0, 1'b0, 8);
    r_vec = '{8'd0, 8'd255, 8'd7, 8'd7, 8'd128, 8'd0, 8'd255, 8'd3};
    do_frame(8, 0, 1'b0, 8);
    r_vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    do_frame(8, 0, 1'b0, 8);
    r_vec = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    do_frame(8, 1, 1'b1, 8);
    r_vec = '{8'd40, 8'd3, 8'd90, 8'd3, 8'd17, 8'd200, 8'd1, 8'd66};
    do_frame(8, 0, 1'b0, 3);
    r_vec = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd8, 8'd6, 8'd3, 8'd7};
    do_frame(8, 0, 1'b0, 8);

    for (int f = 0; f < 24; f++) begin
      for (int w = 0; w < 8; w++) r_vec[w] = 8'($urandom);
      do_frame(8, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 8);
    end

`ifdef BITONIC_STREAM_LAST_EN
    r_vec = '{8'd9, 8'd2, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    do_frame(3, 0, 1'b0, 8);
    for (int f = 0; f < 16; f++) begin
      for (int w = 0; w < 8; w++) r_vec[w] = 8'($urandom);
      do_frame($urandom_range(1, 8), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 8);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bitonic_stream_sorter.md
Name: bitonic_stream_sorter

Overview:
- Sequential counterpart to the team's combinational bitonic merge stages.
- Accepts 8 unsigned words serially over a valid/ready stream and runs the full 8-input bitonic sort network in time, applying 4 compare-exchanges per cycle over 6 steps.
- Streams the sorted result back out serially over a second valid/ready interface.
- Sits between a serial data source and any serial consumer, which replaces 8-wide parallel buses at the block boundary.

Parameters:
WIDTH, 8, data word width in bits (unsigned compare)
DESCEND, 0, 0 = output smallest first; 1 = output largest first

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source presents in_data
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  input word
out_valid  output  1  out_data holds a valid sorted word
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  sorted output word
busy  output  1  high in SORT and OUT states

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All state is held in registers clocked on the `clk` rising edge.
- Storage: `buf[0..7]` of WIDTH bits, plus a 3-bit index `idx` and a 3-bit step counter `step`.
- Reset: state = LOAD, idx = 0, step = 0, in_ready = 1, out_valid = 0, out_data = 0, busy = 0. Buffer contents are don't-care.
- Reset asserted mid-operation aborts immediately. Partial loads and partial outputs are discarded, and there is no residual output after reset release.
- LOAD state:
  - in_ready = 1.
  - Each in_valid & in_ready edge writes buf[idx] = in_data and increments idx.
  - On the 8th accept (idx = 7): go to SORT with step = 0 and idx = 0.
  - in_valid low inserts bubbles; no timeout.
- SORT state:
  - in_ready = 0, out_valid = 0, busy = 1.
  - Each cycle applies one network step (k, j): step0 (2,1), step1 (4,2), step2 (4,1), step3 (8,4), step4 (8,2), step5 (8,1).
  - For every i with (i & j) == 0, partner p = i + j.
  - Pair is ascending when ((i & k) == 0) XOR DESCEND. Ascending puts the smaller value in buf[i]; descending puts the larger value in buf[i].
  - Ties do not swap.
  - Exactly 6 cycles. After step5 go to OUT with idx = 0.
  - Latency: out_valid rises after the 6th edge following the edge that captured the 8th input word.
- OUT state:
  - out_valid = 1, out_data = buf[idx] (driven from registers, stable while stalled), busy = 1.
  - Each out_valid & out_ready edge increments idx.
  - out_ready low holds out_data and out_valid unchanged.
  - After the 8th accepted word: return to LOAD with idx = 0. in_ready goes to 1 on the next cycle; there is no same-cycle overlap of output and load.
- in_valid during SORT or OUT is ignored and data is not captured.
- Words are unsigned and no width growth occurs. Comparisons are full WIDTH magnitude.

Optional Feature:
- Macro: BITONIC_STREAM_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit), high together with out_valid only while idx = 7 in OUT. Reset value is 0.
  - Adds input port in_last (1 bit). If in_last is high on an accepted word before the 8th, the remaining slots are filled with the padding value and SORT starts on the next edge.
  - Padding value is all-ones when DESCEND = 0 and all-zeros when DESCEND = 1, so padding emerges last.
  - The consumer still receives 8 words.
- Undefined:
  - Neither port exists.
  - Every frame is exactly 8 words; behaviour is otherwise identical.

Test Plan:
- Reverse order: DESCEND = 0, inputs 8,7,6,5,4,3,2,1 back-to-back, out_ready = 1 -> outputs 1,2,3,4,5,6,7,8. out_valid first rises 6 edges after the 8th input capture. busy is high from capture until the last output.
- Duplicates and extremes: inputs 0,255,7,7,128,0,255,3 -> outputs 0,0,3,7,7,128,255,255.
- Descending build: DESCEND = 1, inputs 1..8 -> outputs 8..1.
- Backpressure: toggle out_ready every other cycle, plus in_valid bubbles during load -> same sorted sequence. out_data is stable while stalled. in_ready stays 0 until the final output is accepted, then 1 on the next cycle.
- Reset mid-OUT: assert rst_n low after 3 outputs -> out_valid = 0 and in_ready = 1 immediately. A new frame 5,1,4,2,8,6,3,7 then sorts to 1..8.
- BITONIC_STREAM_LAST_EN defined: send 9,2,5 with in_last on the 3rd word -> outputs 2,5,9,255,255,255,255,255. out_last is high only on the 8th word.
